ltc2308_ctrl: RTL and testbench
===============================

LTC2308_CTRL -- requirements
Module: ltc2308_ctrl

Interface
REQ-001 Parameter SCLK_DIV, default 2, sets the SCLK half-period in CLOCK_50 cycles (2 gives 12.5 MHz), legal range 1..255.
REQ-002 Parameter CONV_CYCLES, default 80, sets the conversion wait in CLOCK_50 cycles (1.6 us), legal range 1..1023.
REQ-003 CLOCK_50  in  1  sole clock; all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  level request; sampled only in IDLE; holding it high gives back-to-back frames.
REQ-006 chan  in  3  single-ended channel for the next conversion; captured with start.
REQ-007 unipolar  in  1  1 = unipolar (UNI bit); captured with start.
REQ-008 ADC_CONVST  out  1  conversion start strobe to LTC2308.
REQ-009 ADC_SCLK  out  1  serial clock; idles low.
REQ-010 ADC_DIN  out  1  6-bit config word, MSB first.
REQ-011 ADC_DOUT  in  1  serial result, MSB first.
REQ-012 busy  out  1  high from start acceptance through the DONE cycle.
REQ-013 sample_valid  out  1  one-cycle strobe; sample and sample_chan are valid in that cycle.
REQ-014 sample  out  12  result of the completed frame's conversion.
REQ-015 sample_chan  out  3  channel that produced sample.

Function
REQ-016 FSM states: IDLE, CONV_HI, CONV_WAIT, SHIFT, DONE.
REQ-017 IDLE -> CONV_HI when start=1: latch chan/unipolar into cfg, assert busy.
REQ-018 CONV_HI lasts exactly 2 cycles with ADC_CONVST=1; ADC_CONVST=0 in every other state.
REQ-019 CONV_WAIT lasts exactly CONV_CYCLES cycles, with SCLK low and DIN low.
REQ-020 SHIFT produces exactly 12 SCLK periods: low SCLK_DIV cycles, then high SCLK_DIV cycles.
REQ-021 DIN changes only while SCLK is low; bit k (k=0..5, MSB first) is stable for the whole of SCLK period k; DIN=0 for periods 6..11.
REQ-022 DOUT is sampled in the cycle of each SCLK rising edge and shifted MSB-first into a 12-bit register.
REQ-023 Config word = {S/D=1, O/S=chan[0], S1=chan[2], S0=chan[1], UNI=unipolar, SLP=0}.
REQ-024 DONE lasts 1 cycle: sample_valid=1, sample=shift register, sample_chan=channel latched in the previous frame.
REQ-025 Result pipelining: each frame's data reflects the config sent in the preceding frame.
REQ-026 First frame after reset reports sample_chan=0.
REQ-027 DONE -> CONV_HI if start=1 (a new config is latched), else DONE -> IDLE.
REQ-028 Frame length with defaults: 2+80+48+1 = 131 cycles.
REQ-029 busy is low only in IDLE.
REQ-030 chan and unipolar changes while busy are ignored until the next acceptance.
REQ-031 sample and sample_chan hold their values between strobes.

Reset
REQ-032 When reset=1 at a clock edge, state=IDLE, ADC_CONVST=0, ADC_SCLK=0, ADC_DIN=0, busy=0, sample_valid=0, sample=0, sample_chan=0, and all counters and the prev-channel register clear.
REQ-033 Reset mid-frame aborts immediately with no sample_valid; the next start begins a clean frame.

Structure
REQ-034 Package ltc2308_pkg holds: the FSM state enum, CFG_BITS=6, DATA_BITS=12, and a function mapping {chan, unipolar} to the 6-bit config word.
REQ-035 Sub-module sclk_gen: a divider producing the SCLK level plus one-cycle rise and fall pulses, enabled only in SHIFT.

Verification
REQ-036 Reset, then start=1 for 1 cycle with chan=5, unipolar=1 -> CONVST high for 2 cycles, 80-cycle wait, DIN sequence 1,1,1,0,1,0 on SCLK periods 0..5, sample_valid at cycle 131.
REQ-037 DOUT model drives 12'hA5C MSB-first on SCLK falling edges -> sample=12'hA5C, sample_chan=0 (first frame).
REQ-038 start held high, chan 3 then 6 -> back-to-back frames with no IDLE cycle; second strobe reports sample_chan=3.
REQ-039 SCLK_DIV=1, CONV_CYCLES=4 -> exactly 12 SCLK pulses per frame, SCLK high 1 cycle each, frame length 31 cycles.
REQ-040 reset asserted at SCLK period 7 -> all outputs 0 the next cycle, no sample_valid, and a following start completes normally.
REQ-041 chan changed mid-frame -> DIN word of the current frame unaffected.

Source files
------------

// File: rtl/ltc2308_pkg.sv
// ltc2308_pkg: shared FSM states, widths and config-word mapping for the LTC2308 controller
package ltc2308_pkg;
  typedef enum logic [2:0] {IDLE, CONV_HI, CONV_WAIT, SHIFT, DONE} state_e;
  localparam int CFG_BITS = 6;
  localparam int DATA_BITS = 12;
  // {S/D, O/S, S1, S0, UNI, SLP}; single-ended, awake
  function automatic logic [CFG_BITS-1:0] cfg_word(input logic [2:0] ch, input logic uni);
    return {1'b1, ch[0], ch[2], ch[1], uni, 1'b0};
  endfunction
endpackage

// File: rtl/ltc2308_ctrl_sclk_gen.sv
// sclk_gen: SCLK divider, low phase first, with rise/fall pulses in the last cycle of each phase
module sclk_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);
  logic [7:0] cnt_q;
  logic       lvl_q;
  logic       wrap;
  assign wrap   = en_i && cnt_q == 8'(DIV - 1);
  assign rise_o = wrap && !lvl_q;
  assign fall_o = wrap && lvl_q;
  assign sclk_o = lvl_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      lvl_q <= ~lvl_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
endmodule

// File: rtl/ltc2308_ctrl.sv
// ltc2308_ctrl: frame sequencer for the LTC2308 ADC (CONVST, wait, 12-bit SPI shift)
module ltc2308_ctrl
  import ltc2308_pkg::*;
#(
  parameter int SCLK_DIV    = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           chan,
  input  logic                 unipolar,
  output logic                 ADC_CONVST,
  output logic                 ADC_SCLK,
  output logic                 ADC_DIN,
  input  logic                 ADC_DOUT,
  output logic                 busy,
  output logic                 sample_valid,
  output logic [DATA_BITS-1:0] sample,
  output logic [2:0]           sample_chan
);
  state_e               state_q;
  logic [9:0]           cnt_q;
  logic [3:0]           bit_q;
  logic [CFG_BITS-1:0]  cfg_q;
  logic [2:0]           chan_q, prev_q, schan_q;
  logic [DATA_BITS-1:0] sh_q, sample_q;
  logic                 conv_q, din_q, busy_q, valid_q;
  logic                 rise, fall;
  sclk_gen #(.DIV(SCLK_DIV)) u_sclk (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .en_i  (state_q == SHIFT),
    .sclk_o(ADC_SCLK),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign ADC_CONVST   = conv_q;
  assign ADC_DIN      = din_q;
  assign busy         = busy_q;
  assign sample_valid = valid_q;
  assign sample       = sample_q;
  assign sample_chan  = schan_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      cfg_q    <= '0;
      chan_q   <= '0;
      prev_q   <= '0;
      schan_q  <= '0;
      sh_q     <= '0;
      sample_q <= '0;
      conv_q   <= 1'b0;
      din_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise) sh_q <= {sh_q[DATA_BITS-2:0], ADC_DOUT};
      case (state_q)
        IDLE, DONE:
          if (start) begin
            state_q <= CONV_HI;
            cfg_q   <= cfg_word(chan, unipolar);
            chan_q  <= chan;
            cnt_q   <= '0;
            conv_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        CONV_HI:
          if (cnt_q == 10'd1) begin
            state_q <= CONV_WAIT;
            cnt_q   <= '0;
            conv_q  <= 1'b0;
          end else cnt_q <= cnt_q + 10'd1;
        CONV_WAIT:
          if (cnt_q == 10'(CONV_CYCLES - 1)) begin
            state_q <= SHIFT;
            din_q   <= cfg_q[CFG_BITS-1];
            cfg_q   <= cfg_q << 1;
            bit_q   <= '0;
          end else cnt_q <= cnt_q + 10'd1;
        SHIFT:
          // DIN advances on the SCLK fall; zeros shift in once the config word is spent
          if (fall) begin
            din_q <= cfg_q[CFG_BITS-1];
            cfg_q <= cfg_q << 1;
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'(DATA_BITS - 1)) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              sample_q <= sh_q;
              schan_q  <= prev_q;
              prev_q   <= chan_q;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ltc2308_ctrl.sv
// tb_ltc2308_ctrl: directed checks of frame timing, config shifting, result pipelining and reset
module tb_ltc2308_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [2:0]  chan = '0;
  logic        unipolar = 1'b0;
  logic        convst, sclk, din, dout = 1'b0, busy, valid;
  logic [11:0] sample, word = '0;
  logic [2:0]  schan;
  logic        convst2, sclk2, din2, busy2, valid2;
  logic [11:0] sample2;
  logic [2:0]  schan2;
  int          vecs = 0, errs = 0, idx = 0;

  always #10 clk = ~clk;

  ltc2308_ctrl dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .chan(chan), .unipolar(unipolar),
    .ADC_CONVST(convst), .ADC_SCLK(sclk), .ADC_DIN(din), .ADC_DOUT(dout),
    .busy(busy), .sample_valid(valid), .sample(sample), .sample_chan(schan)
  );

  ltc2308_ctrl #(.SCLK_DIV(1), .CONV_CYCLES(4)) dut2 (
    .CLOCK_50(clk), .reset(reset), .start(start2), .chan(chan), .unipolar(unipolar),
    .ADC_CONVST(convst2), .ADC_SCLK(sclk2), .ADC_DIN(din2), .ADC_DOUT(1'b1),
    .busy(busy2), .sample_valid(valid2), .sample(sample2), .sample_chan(schan2)
  );

  // ADC model: MSB appears with CONVST, later bits follow each SCLK fall
  always @(posedge convst or negedge sclk) begin
    idx  = convst ? 0 : idx + 1;
    dout = (idx < 12) ? word[11 - idx] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 of a frame (first CONV_HI cycle); checks cycles 1..last
  task automatic run_frame(input logic [5:0] cfg, input int last, input logic drop,
                           input logic [2:0] nc, input logic [11:0] es, input logic [2:0] ech);
    for (int c = 1; c <= last; c++) begin
      logic esclk, edin;
      esclk = c >= 83 && c <= 130 && ((c - 83) % 4) >= 2;
      edin  = (c >= 83 && c <= 130 && (c - 83) / 4 < 6) ? cfg[5 - (c - 83) / 4] : 1'b0;
      chk($sformatf("convst@%0d", c), convst, c <= 2);
      chk($sformatf("sclk@%0d", c), sclk, esclk);
      chk($sformatf("din@%0d", c), din, edin);
      chk($sformatf("busy@%0d", c), busy, 1'b1);
      chk($sformatf("valid@%0d", c), valid, c == 131);
      if (c == 131) begin
        chk("sample", sample, es);
        chk("sample_chan", schan, ech);
      end
      if (c == 1 && drop) start = 1'b0;
      if (c == 40) chan = nc;
      if (c < last) @(negedge clk);
    end
  endtask

  initial begin
    int done2, rises, highs, convs;
    logic prev;
    repeat (3) @(negedge clk);
    chk("rst_convst", convst, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_sample", sample, 0);
    chk("rst_schan", schan, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    // single frame, chan 5 unipolar, chan disturbed mid-frame
    start = 1'b1; chan = 3'd5; unipolar = 1'b1; word = 12'hA5C;
    @(negedge clk);
    run_frame(6'b111010, 131, 1'b1, 3'd2, 12'hA5C, 3'd0);
    repeat (3) begin
      @(negedge clk);
      chk("post_busy", busy, 0);
      chk("post_valid", valid, 0);
      chk("hold_sample", sample, 12'hA5C);
      chk("hold_schan", schan, 0);
    end
    // back-to-back: chan 3 then 6, start held across DONE
    start = 1'b1; chan = 3'd3; unipolar = 1'b0; word = 12'h3C6;
    @(negedge clk);
    run_frame(6'b110100, 131, 1'b0, 3'd6, 12'h3C6, 3'd5);
    word = 12'h5A3;
    @(negedge clk);
    run_frame(6'b101100, 131, 1'b1, 3'd1, 12'h5A3, 3'd3);
    @(negedge clk);
    chk("b2b_idle", busy, 0);
    // reset during SCLK period 7
    start = 1'b1; chan = 3'd1; unipolar = 1'b1; word = 12'hFFF;
    @(negedge clk);
    run_frame(6'b110010, 113, 1'b1, 3'd1, 12'h000, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_convst", convst, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_din", din, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_sample", sample, 0);
    chk("abort_schan", schan, 0);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("abort_quiet_valid", valid, 0);
      chk("abort_quiet_busy", busy, 0);
    end
    start = 1'b1; chan = 3'd4; unipolar = 1'b0; word = 12'h0FF;
    @(negedge clk);
    run_frame(6'b101000, 131, 1'b1, 3'd7, 12'h0FF, 3'd0);
    // fast instance: SCLK_DIV=1, CONV_CYCLES=4
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    done2 = 0; rises = 0; highs = 0; convs = 0; prev = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (convst2) convs++;
      if (sclk2) highs++;
      if (sclk2 && !prev) rises++;
      prev = sclk2;
      if (valid2) begin
        done2 = c;
        break;
      end
      @(negedge clk);
    end
    chk("fast_frame_len", done2, 31);
    chk("fast_sclk_pulses", rises, 12);
    chk("fast_sclk_high_cycles", highs, 12);
    chk("fast_convst_cycles", convs, 2);
    chk("fast_sample", sample2, 12'hFFF);
    chk("fast_schan", schan2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
